// File: rtl/ram_port_ctrl_pkg.sv
// rtl/ram_port_ctrl_pkg.sv - shared FSM type, default widths and tick-counter sizing for ram_port_ctrl
package ram_port_pkg;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 4;
  localparam int DEF_TICK_DIV = 50_000_000;
  localparam int TICK_W       = $clog2(DEF_TICK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WRITE,
    RD_ISSUE,
    RD_WAIT
  } state_t;

  // Counter width for a divider; a width of at least one bit keeps tiny dividers legal.
  function automatic int tick_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/ram_port_ctrl_if.sv
// rtl/ram_port_ctrl_if.sv - user write inputs, RAM port and scan outputs bundled for ram_port_ctrl
interface ram_port_if
  import ram_port_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              wr_btn;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  logic              busy;

  // Controller side
  modport master (
    input  wr_btn, wr_addr, wr_data, ram_q,
    output ram_addr, ram_data, ram_wren, scan_addr, scan_data, scan_valid, busy
  );

  // Board / RAM / display side
  modport slave (
    output wr_btn, wr_addr, wr_data, ram_q,
    input  ram_addr, ram_data, ram_wren, scan_addr, scan_data, scan_valid, busy
  );

endinterface

// File: rtl/ram_port_ctrl_key_edge_sync.sv
// rtl/ram_port_ctrl_key_edge_sync.sv - two-flop synchronizer with single-cycle rising-edge pulse
module key_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [2:0] sync_q;

  // Stages 0/1 resynchronize the button, stage 2 remembers the previous level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], din};
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ram_port_ctrl.sv
// rtl/ram_port_ctrl.sv - RAM port arbiter between button writes and periodic scan reads; RAM_PORT_CTRL_INIT_EN adds clear-on-reset
module ram_port_ctrl
  import ram_port_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int RD_LAT   = 1
) (
  input logic        clock,
  input logic        reset,
  ram_port_if.master bus
);

  localparam int CNT_W = tick_width(TICK_DIV);
  localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

`ifdef RAM_PORT_CTRL_INIT_EN
  localparam state_t RESET_ST = INIT;
`else
  localparam state_t RESET_ST = IDLE;
`endif

  state_t            state_q, state_d;
  logic              wr_rise;
  logic              wr_pend;
  logic              rd_pend;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick_done;
  logic [ADDR_W-1:0] scan_ptr;
  logic [LAT_W-1:0]  lat_cnt;
  logic              lat_done;
  logic [ADDR_W-1:0] addr_q, addr_c;
  logic [DATA_W-1:0] data_q, data_c;
  logic              wren_c;
  logic [ADDR_W-1:0] scan_addr_q;
  logic [DATA_W-1:0] scan_data_q;
  logic              scan_valid_q;
`ifdef RAM_PORT_CTRL_INIT_EN
  logic [ADDR_W-1:0] init_ptr;
`endif

  key_edge_sync u_key (
    .clock (clock),
    .reset (reset),
    .din   (bus.wr_btn),
    .rise  (wr_rise)
  );

  assign tick_done = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign lat_done  = (lat_cnt == LAT_W'(RD_LAT - 1));

  // Latch the user request on its edge; one request may wait while the port is busy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_addr <= '0;
      hold_data <= '0;
      wr_pend   <= 1'b0;
    end else begin
      if (wr_rise && !wr_pend) begin
        hold_addr <= bus.wr_addr;
        hold_data <= bus.wr_data;
      end
      // IDLE always dispatches a live or pending write, so the flag only survives outside IDLE
      if (state_q == IDLE) wr_pend <= 1'b0;
      else if (wr_rise)    wr_pend <= 1'b1;
    end
  end

  // Free-running scan divider; a tick arms one read, later ticks merge into it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      rd_pend  <= 1'b0;
    end else begin
      tick_cnt <= tick_done ? '0 : tick_cnt + CNT_W'(1);
      if (tick_done)               rd_pend <= 1'b1;
      else if (state_q == RD_ISSUE) rd_pend <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RESET_ST;
    else       state_q <= state_d;
  end

  // Next state and RAM port drive; address/data hold their last value when idle
  always_comb begin
    state_d = state_q;
    addr_c  = addr_q;
    data_c  = data_q;
    wren_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_rise || wr_pend) state_d = WRITE;
        else if (rd_pend)       state_d = RD_ISSUE;
      end
      WRITE: begin
        addr_c  = hold_addr;
        data_c  = hold_data;
        wren_c  = 1'b1;
        state_d = IDLE;
      end
      RD_ISSUE: begin
        addr_c  = scan_ptr;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        addr_c = scan_ptr;
        if (lat_done) state_d = IDLE;
      end
`ifdef RAM_PORT_CTRL_INIT_EN
      INIT: begin
        addr_c = init_ptr;
        data_c = '0;
        wren_c = 1'b1;
        if (init_ptr == {ADDR_W{1'b1}}) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Remember the last driven address/data so idle cycles keep the bus stable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      addr_q <= addr_c;
      data_q <= data_c;
    end
  end

  // Read latency count, result capture and scan pointer advance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_cnt      <= '0;
      scan_ptr     <= '0;
      scan_addr_q  <= '0;
      scan_data_q  <= '0;
      scan_valid_q <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      if (state_q == RD_ISSUE)                lat_cnt <= '0;
      else if (state_q == RD_WAIT && !lat_done) lat_cnt <= lat_cnt + LAT_W'(1);
      if (state_q == RD_WAIT && lat_done) begin
        scan_data_q  <= bus.ram_q;
        scan_addr_q  <= scan_ptr;
        scan_valid_q <= 1'b1;
        scan_ptr     <= scan_ptr + ADDR_W'(1);
      end
    end
  end

`ifdef RAM_PORT_CTRL_INIT_EN
  // Clear-sweep pointer used only while in INIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 init_ptr <= '0;
    else if (state_q == INIT)  init_ptr <= init_ptr + ADDR_W'(1);
  end
`endif

  // Reset gates the strobes so wren/busy drop the instant reset rises, whatever the reset state
  assign bus.ram_addr   = addr_c;
  assign bus.ram_data   = data_c;
  assign bus.ram_wren   = wren_c & ~reset;
  assign bus.scan_addr  = scan_addr_q;
  assign bus.scan_data  = scan_data_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.busy       = (state_q != IDLE) & ~reset;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb/tb_ram_port_ctrl.sv - scoreboard bench for ram_port_ctrl with a behavioural ram32x4
module tb_ram_port_ctrl;
  import ram_port_pkg::*;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 4;
  localparam int TICK_DIV = 8;
  localparam int RD_LAT   = 1;
  localparam int DEPTH    = 32;
  localparam int BUDGET   = 700;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TICK_DIV (TICK_DIV),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  wr_t wq[$];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  function automatic logic [DATA_W-1:0] pu_val(input int i);
    return DATA_W'((i * 7 + 3) & 15);
  endfunction

  function automatic logic [DATA_W-1:0] base_val(input int i);
`ifdef RAM_PORT_CTRL_INIT_EN
    return '0;
`else
    return pu_val(i);
`endif
  endfunction

  // Behavioural ram32x4: registered address, unregistered q, power-up pattern from pu_val
  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic [ADDR_W-1:0] ram_addr_r;
  bit ram_ready;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= pu_val(i);
      ram_ready <= 1'b1;
    end else if (bus.ram_wren) begin
      ram_mem[bus.ram_addr] <= bus.ram_data;
    end
    ram_addr_r <= bus.ram_addr;
  end
  assign bus.ram_q = ram_mem[ram_addr_r];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_init();
    wr_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.addr = ADDR_W'(i);
      e.data = '0;
      wq.push_back(e);
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic wait_scan_addr(input logic [ADDR_W-1:0] a, input string tag);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (bus.scan_valid && bus.scan_addr == a) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for scan_addr=%0d", tag, a);
    end
  endtask

  task automatic next_scan_addr(output logic [ADDR_W-1:0] a);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    a = '1;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.scan_valid) begin
        got = 1'b1;
        a = bus.scan_addr;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL next_scan timeout");
    end
  endtask

  // Monitor: checks every write strobe against the queue and every scan result against the model
  initial begin : monitor
    wr_t e;
    wr_t stg;
    bit stg_valid;
    bit prev_valid;
    logic [ADDR_W-1:0] exp_ptr;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = pu_val(i);
    stg_valid  = 1'b0;
    prev_valid = 1'b0;
    exp_ptr    = '0;
    forever begin
      @(negedge clk);
      // a write seen last cycle lands in the model only if reset did not abort it
      if (stg_valid && !rst) exp_mem[stg.addr] = stg.data;
      stg_valid = 1'b0;
      if (rst) begin
        exp_ptr    = '0;
        prev_valid = 1'b0;
      end else begin
        if (bus.ram_wren) begin
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%0h", bus.ram_addr, bus.ram_data);
          end else begin
            e = wq.pop_front();
            if (bus.ram_addr !== e.addr || bus.ram_data !== e.data || bus.busy !== 1'b1) begin
              errors++;
              $display("FAIL write actual addr=%0d data=%0h busy=%0b required addr=%0d data=%0h busy=1",
                       bus.ram_addr, bus.ram_data, bus.busy, e.addr, e.data);
            end
            stg = e;
            stg_valid = 1'b1;
          end
        end
        if (bus.scan_valid) begin
          checks++;
          if (prev_valid || bus.scan_addr !== exp_ptr || bus.scan_data !== exp_mem[exp_ptr]) begin
            errors++;
            $display("FAIL scan actual addr=%0d data=%0h back_to_back=%0b required addr=%0d data=%0h",
                     bus.scan_addr, bus.scan_data, prev_valid, exp_ptr, exp_mem[exp_ptr]);
          end
          exp_ptr++;
        end
        prev_valid = bus.scan_valid;
      end
    end
  end

  // Directed stimulus
  initial begin : stim
    int n;
    bit got;
    logic [ADDR_W-1:0] sa;
    bus.wr_btn  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {11'd0, bus.ram_addr, bus.ram_data, bus.ram_wren, bus.scan_addr,
                            bus.scan_data, bus.scan_valid, bus.busy}, 32'd0);
`ifdef RAM_PORT_CTRL_INIT_EN
    push_init();
`endif
    rst = 1'b0;

    // idle scanning: pulse spacing equals the divider
    wait_scan_addr(1, "idle_scan");
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.scan_valid) got = 1'b1;
    end
    check("scan_period", n, TICK_DIV);

    // long press produces one write, later read back by the scan
    @(negedge clk);
    push_wr(5'd1, 4'b1100);
    bus.wr_btn = 1'b1;
    repeat (5) @(negedge clk);
    bus.wr_btn = 1'b0;
    wait_scan_addr(1, "readback_1");
    check("scan_data_addr1", bus.scan_data, 4'b1100);

    // write edge lands on the terminal tick: write first, then the read of the same address
    wait_scan_addr(2, "align_tick");
    repeat (2) @(negedge clk);
    push_wr(5'd3, 4'b1000);
    bus.wr_btn = 1'b1;
    repeat (5) @(negedge clk);
    bus.wr_btn = 1'b0;
    wait_scan_addr(3, "readback_3");
    check("scan_data_addr3", bus.scan_data, 4'b1000);

    // write edge arrives during RD_ISSUE: read returns old data, write is serviced afterwards
    wait_scan_addr(5, "align_read");
    repeat (4) @(negedge clk);
    push_wr(5'd6, 4'b0110);
    bus.wr_btn = 1'b1;
    wait_scan_addr(6, "read_during_pend");
    check("scan_data_addr6_old", bus.scan_data, base_val(6));
    bus.wr_btn = 1'b0;

    // pointer wrap 31 -> 0 -> 1
    wait_scan_addr(31, "wrap");
    next_scan_addr(sa);
    check("wrap_addr0", sa, 0);
    next_scan_addr(sa);
    check("wrap_addr1", sa, 1);
    wait_scan_addr(6, "readback_6");
    check("scan_data_addr6_new", bus.scan_data, 4'b0110);

    // reset during the WRITE cycle aborts the write immediately
    @(negedge clk);
    push_wr(5'd9, 4'b1111);
    bus.wr_btn = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.ram_wren) got = 1'b1;
    end
    check("wren_seen_before_abort", got, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_wren", bus.ram_wren, 0);
    check("abort_outputs", {11'd0, bus.ram_addr, bus.ram_data, bus.ram_wren, bus.scan_addr,
                            bus.scan_data, bus.scan_valid, bus.busy}, 32'd0);
    bus.wr_btn = 1'b0;
    repeat (3) @(negedge clk);
`ifdef RAM_PORT_CTRL_INIT_EN
    push_init();
`endif
    rst = 1'b0;
    wait_scan_addr(9, "after_abort");
    check("scan_data_addr9_unwritten", bus.scan_data, base_val(9));

    repeat (4) @(negedge clk);
    check("write_queue_drained", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_ctrl.md
Name: ram_port_ctrl

Overview:
- Single-port access controller placed directly upstream of the 32x4 on-chip RAM (ram32x4).
- Drives the RAM address, data and write-enable, and arbitrates between user writes (switches plus push-button) and a periodic auto-scan read.
- The auto-scan walks every address and presents each location's contents to downstream display logic (LEDR/HEX).

Parameters:
- ADDR_W, 5, RAM address width; depth = 2**ADDR_W.
- DATA_W, 4, RAM word width.
- TICK_DIV, 50_000_000, clock cycles between scan reads (1 s at 50 MHz); minimum 4.
- RD_LAT, 1, cycles from address-issue edge until ram_q is valid (1 = unregistered q, 2 = registered q).

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- wr_btn  in  1  write request, active-high level (top connects ~KEY[0]); asynchronous to clock.
- wr_addr  in  ADDR_W  write address (SW[4:0]).
- wr_data  in  DATA_W  write data (SW[8:5]).
- ram_addr  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_wren  out  1  to RAM wren.
- ram_q  in  DATA_W  from RAM q.
- scan_addr  out  ADDR_W  address of the last completed scan read.
- scan_data  out  DATA_W  data of the last completed scan read.
- scan_valid  out  1  one-cycle pulse when scan_addr/scan_data update.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0; scan pointer 0; tick counter 0; read-pending flag 0; FSM in IDLE (or INIT, see Optional Feature).
- wr_btn passes through a 2-flop synchronizer, then a rising-edge detector. One press produces exactly one write regardless of hold time.
- On the detected edge, wr_addr and wr_data are latched into holding registers.
- Tick counter runs 0..TICK_DIV-1 and wraps. At terminal count it sets read_pending, which stays set until a read is issued.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT.
- IDLE, write edge present -> WRITE. Writes have priority over reads.
- IDLE, read_pending set and no write edge -> RD_ISSUE.
- WRITE, one cycle: ram_addr = latched address, ram_data = latched data, ram_wren = 1 -> IDLE. ram_wren is never high in any other state.
- RD_ISSUE: ram_addr = scan pointer, ram_wren = 0; clear read_pending -> RD_WAIT.
- RD_WAIT: hold ram_addr for RD_LAT cycles, then capture ram_q into scan_data and the pointer into scan_addr, pulse scan_valid, increment the pointer modulo 2**ADDR_W (31 -> 0) -> IDLE.
- Write edge arriving outside IDLE is held in a one-deep pending register and serviced on the next IDLE. A further edge while one is already pending is dropped.
- Simultaneous tick and write edge: write executes first, read follows. A read of the just-written address returns the new data.
- Tick while read_pending is already set: no extra read is queued.
- ram_data and ram_addr outside WRITE/RD states: hold last value, wren = 0.
- Reset asserted mid-operation: immediate return to reset values; an in-flight write is aborted with wren forced to 0 asynchronously.

Optional Feature:
- Macro: RAM_PORT_CTRL_INIT_EN.
- Defined: after reset the FSM enters state INIT and writes 0 to every address 0..2**ADDR_W-1, one per cycle (2**ADDR_W cycles, wren = 1, busy = 1), then goes to IDLE. Write edges and ticks during INIT are retained per the pending rules above and serviced afterwards.
- Undefined: no INIT state; FSM leaves reset directly in IDLE and RAM contents are whatever the RAM powered up with.

Decomposition:
- Package ram_port_pkg holds:
  - state enum type (IDLE, INIT, WRITE, RD_ISSUE, RD_WAIT);
  - default ADDR_W/DATA_W constants;
  - localparam for the tick-counter width, $clog2(TICK_DIV).
- One sub-module: key_edge_sync (2-flop synchronizer plus rising-edge pulse, async active-high reset).

Test Plan (bench uses TICK_DIV = 8, RD_LAT = 1):
- Reset release with no stimulus -> ram_wren stays 0; scan_valid pulses every 8 cycles with scan_addr 0, 1, 2, …
- wr_btn held high 5 cycles with wr_addr = 1, wr_data = 4'b1100 -> exactly one cycle of ram_wren = 1, ram_addr = 1, ram_data = 4'b1100. The scan read of address 1 later reports scan_data = 4'b1100.
- Write edge in the same cycle as the terminal tick, both targeting address 3, wr_data = 4'b1000 -> WRITE occurs first, then the read. If the scan pointer is 3, scan_data = 4'b1000.
- Run 33 scan reads -> scan_addr sequence goes 31 -> 0 -> 1 with no glitch on scan_valid.
- Assert reset during the WRITE cycle -> ram_wren drops to 0 in the same cycle; all outputs return to 0.
- With RAM_PORT_CTRL_INIT_EN defined -> busy high for 32 cycles after reset with ram_addr stepping 0..31 and data 0. All subsequent scan reads return 0 until a write occurs.
